pipe_hazard_ctrl: RTL and testbench

Hazard-control block for the parametrised five-stage MIPS pipeline. It keeps a shift-register scoreboard of destination registers in flight between ID and WB, and detects read-after-write hazards for the instruction in ID. It drives stall, flush and (optionally) operand-forwarding selects to the IF/ID/EXE stage registers. It replaces the free-running pipeline, which had no interlocks, and sits beside the ID stage in the top-level pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard control for the five-stage pipeline: in-flight destination scoreboard, stall/flush
// generation and registered operand-forward selects (forwarding compiled in with `define FORWARDING_EN).
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src2,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_sel1,
  output logic [1:0]            fwd_sel2,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_r;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  // Entry 0 is EXE, entry DEPTH-1 is WB.
  sb_entry_t sb [DEPTH];

  // Per-entry source matches; the WB entry is excluded since the register file writes through.
  logic [DEPTH-2:0] m1, m2;
  logic             hazard;
  logic             issue;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      m1[k] = sb[k].valid && sb[k].wb_en && (sb[k].dest == id_src1) && (id_src1 != '0);
      m2[k] = sb[k].valid && sb[k].wb_en && (sb[k].dest == id_src2) && (id_src2 != '0)
              && id_use_src2;
    end
  end

  always_comb begin
    hazard = 1'b0;
`ifdef FORWARDING_EN
    // EXE results forward from MEM next cycle; only a load in EXE is too late.
    hazard = sb[0].mem_r && (m1[0] || m2[0]);
    for (int unsigned k = 2; k < DEPTH - 1; k++) begin
      hazard = hazard | m1[k] | m2[k];
    end
`else
    hazard = |{m1, m2};
`endif
  end

  assign flush = branch_taken;
  assign stall = id_valid && hazard && !branch_taken;
  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      if (issue) begin
        sb[0] <= '{valid: 1'b1, wb_en: id_wb_en, mem_r: id_mem_r_en, dest: id_dest};
      end else begin
        sb[0] <= '0;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

`ifdef FORWARDING_EN
  // Selects are judged from the ID view, so entry 0 becomes MEM and entry 1 becomes WB.
  function automatic logic [1:0] fwd_pick(input logic [1:0] m);
    if (m[0]) return 2'd1;
    if (m[1]) return 2'd2;
    return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      fwd_sel1 <= '0;
      fwd_sel2 <= '0;
    end else begin
      fwd_sel1 <= fwd_pick(m1[1:0]);
      fwd_sel2 <= fwd_pick(m2[1:0]);
    end
  end
`else
  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: per-cycle stimulus and expected outputs are queued, then
// replayed and compared; expectations follow FORWARDING_EN when it is defined for the build.
module tb_pipe_hazard_ctrl;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_src1, id_src2, id_dest;
  logic          id_use_src2, id_wb_en, id_mem_r_en, branch_taken;
  logic          stall, flush;
  logic [1:0]    fwd_sel1, fwd_sel2;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .DEPTH(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_dest(id_dest), .branch_taken(branch_taken), .stall(stall), .flush(flush),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic          rst, valid;
    logic [RW-1:0] s1, s2;
    logic          use2, wb, memr;
    logic [RW-1:0] dest;
    logic          br;
  } stim_t;

  stim_t      sq[$];
  logic [9:0] eq[$];   // {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}
  int         nerr = 0;
  int         nchk = 0;
  logic [CW-1:0] exp_cnt;
  logic [1:0]    pend1, pend2;

  function automatic stim_t mk(input logic r, input logic v, input int s1, input int s2,
                               input logic u2, input logic wb, input logic mr, input int d,
                               input logic br);
    stim_t s;
    s.rst = r; s.valid = v; s.s1 = RW'(s1); s.s2 = RW'(s2); s.use2 = u2;
    s.wb = wb; s.memr = mr; s.dest = RW'(d); s.br = br;
    return s;
  endfunction

  stim_t idle;

  // Queue one cycle: outputs registered at the previous edge, combinational flags for this stimulus.
  task automatic add(input stim_t s, input logic stl, input logic fl,
                     input logic [1:0] f1, input logic [1:0] f2);
    logic [1:0] g1, g2;
`ifdef FORWARDING_EN
    g1 = f1; g2 = f2;
`else
    g1 = 2'd0; g2 = 2'd0;
`endif
    sq.push_back(s);
    eq.push_back({stl, fl, pend1, pend2, exp_cnt});
    if (s.rst) exp_cnt = '0;
    else if (stl && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    if (s.rst || stl || fl || !s.valid) begin
      pend1 = 2'd0; pend2 = 2'd0;
    end else begin
      pend1 = g1; pend2 = g2;
    end
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; id_valid = s.valid; id_src1 = s.s1; id_src2 = s.s2; id_use_src2 = s.use2;
    id_wb_en = s.wb; id_mem_r_en = s.memr; id_dest = s.dest; branch_taken = s.br;
  endtask

  task automatic test_reset();
    stim_t r, s;
    logic [9:0] e;
    exp_cnt = '0; pend1 = '0; pend2 = '0;
    r = mk(1, 1, 1, 2, 1, 1, 0, 1, 0);
    apply(r);
    add(r, 0, 0, 0, 0); add(r, 0, 0, 0, 0);
    add(idle, 0, 0, 0, 0); add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL reset cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  task automatic test_alu_dep();
    stim_t a, b, s;
    logic [9:0] e;
    a = mk(0, 1, 1, 2, 1, 1, 0, 3, 0);
    b = mk(0, 1, 3, 5, 1, 1, 0, 4, 0);
`ifdef FORWARDING_EN
    add(a, 0, 0, 0, 0); add(b, 0, 0, 1, 0);
`else
    add(a, 0, 0, 0, 0); add(b, 1, 0, 0, 0); add(b, 1, 0, 0, 0); add(b, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 3; i++) add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL alu_dep cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t l, u, s;
    logic [9:0] e;
    l = mk(0, 1, 1, 0, 0, 1, 1, 7, 0);
    u = mk(0, 1, 7, 7, 1, 1, 0, 8, 0);
`ifdef FORWARDING_EN
    add(l, 0, 0, 0, 0); add(u, 1, 0, 0, 0); add(u, 0, 0, 2, 2);
`else
    add(l, 0, 0, 0, 0); add(u, 1, 0, 0, 0); add(u, 1, 0, 0, 0); add(u, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 3; i++) add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL load_use cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  task automatic test_reg0();
    stim_t s;
    logic [9:0] e;
    add(mk(0, 1, 1, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0);
    add(mk(0, 1, 0, 0, 1, 1, 0, 9, 0), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL reg0 cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  // A consumer of the flushed instruction's dest exposes whether it leaked into entry 0.
  task automatic test_branch_flush();
    stim_t s;
    logic [9:0] e;
    add(mk(0, 1, 1, 0, 0, 1, 1, 3, 0), 0, 0, 0, 0);
    add(mk(0, 1, 3, 0, 0, 1, 0, 4, 1), 0, 1, 0, 0);
    add(mk(0, 1, 4, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL branch_flush cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    logic [9:0] e;
    for (int i = 0; i < 20; i++) begin
      s = mk(0, 1, (i == 0) ? 1 : 9 + i, 0, 0, 1, 1, 10 + i, 0);
      if (i == 0) add(s, 0, 0, 0, 0);
      else begin
`ifdef FORWARDING_EN
        add(s, 1, 0, 0, 0); add(s, 0, 0, 2, 0);
`else
        add(s, 1, 0, 0, 0); add(s, 1, 0, 0, 0); add(s, 0, 0, 0, 0);
`endif
      end
    end
    for (int i = 0; i < 3; i++) add(idle, 0, 0, 0, 0);
    for (int c = 0; sq.size() > 0; c++) begin
      s = sq.pop_front(); @(posedge clk); #1 apply(s); @(negedge clk);
      e = eq.pop_front(); nchk++;
      if ({stall, flush, fwd_sel1, fwd_sel2, stall_cnt} !== e)
        begin nerr++; $display("FAIL saturation cyc=%0d got=%b want=%b", c,
          {stall, flush, fwd_sel1, fwd_sel2, stall_cnt}, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_dep();
    test_load_use();
    test_reg0();
    test_branch_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
